// File: rtl/inlet_dose_sequencer_if.sv
// inlet_dose_sequencer_if: host-side start/abort/dose-length bus and valve/pump/status outputs.
interface inlet_dose_sequencer_if #(parameter int CNT_W = 16);
  logic             start_i;
  logic             abort_i;
  logic [CNT_W-1:0] dose1_len_i;
  logic [CNT_W-1:0] dose2_len_i;
  logic [CNT_W-1:0] dose3_len_i;
  logic             valve_soln1_o;
  logic             valve_soln2_o;
  logic             valve_soln3_o;
  logic             pump_en_o;
  logic             busy_o;
  logic             done_o;
  logic             aborted_o;
  modport master (
    output start_i, abort_i, dose1_len_i, dose2_len_i, dose3_len_i,
    input  valve_soln1_o, valve_soln2_o, valve_soln3_o, pump_en_o, busy_o, done_o, aborted_o
  );
  modport slave (
    input  start_i, abort_i, dose1_len_i, dose2_len_i, dose3_len_i,
    output valve_soln1_o, valve_soln2_o, valve_soln3_o, pump_en_o, busy_o, done_o, aborted_o
  );
endinterface

// File: rtl/inlet_dose_sequencer.sv
// inlet_dose_sequencer: timed dose/settle/flush sequencer for the three inlet valves and pump.
// Define INLET_SEQ_BREAK_GAP_EN to insert a one-cycle all-closed GAP between valve-open phases.
module inlet_dose_sequencer #(
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 300,
  parameter int FLUSH_CYC  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  inlet_dose_sequencer_if.slave  bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DOSE1  = 3'd1;
  localparam logic [2:0] DOSE2  = 3'd2;
  localparam logic [2:0] DOSE3  = 3'd3;
  localparam logic [2:0] SETTLE = 3'd4;
  localparam logic [2:0] FLUSH  = 3'd5;
`ifdef INLET_SEQ_BREAK_GAP_EN
  localparam logic [2:0] GAP    = 3'd6;
  logic [2:0] tgt_q, tgt_d;
`endif
  logic [2:0]       state_q, state_d, nxt, succ;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len1_q, len1_d, len2_q, len2_d, len3_q, len3_d;
  logic             aborted_q, aborted_d, done_q, done_d, go, is_dose;
  logic [3:0]       drv_q, drv_d;
  function automatic logic [CNT_W-1:0] m1(input logic [CNT_W-1:0] x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction
  always_comb begin
    state_d   = state_q;
    len1_d    = len1_q;
    len2_d    = len2_q;
    len3_d    = len3_q;
    aborted_d = aborted_q;
    cnt_d     = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    is_dose   = state_q inside {DOSE1, DOSE2, DOSE3};
    succ      = state_q == DOSE1 ? DOSE2 : state_q == DOSE2 ? DOSE3 :
                state_q == DOSE3 ? SETTLE : state_q == SETTLE ? FLUSH : IDLE;
`ifdef INLET_SEQ_BREAK_GAP_EN
    tgt_d = tgt_q;
    if (state_q == GAP) succ = tgt_q;
`endif
    go  = 1'b0;
    nxt = IDLE;
    if (state_q == IDLE) begin
      if (bus.start_i && !bus.abort_i) begin
        go        = 1'b1;
        nxt       = DOSE1;
        len1_d    = bus.dose1_len_i;
        len2_d    = bus.dose2_len_i;
        len3_d    = bus.dose3_len_i;
        aborted_d = 1'b0;
      end
    end else if (bus.abort_i && state_q != FLUSH) begin
      go        = 1'b1;
      aborted_d = 1'b1;
`ifdef INLET_SEQ_BREAK_GAP_EN
      nxt   = (is_dose || (state_q == GAP && tgt_q != FLUSH)) ? GAP : FLUSH;
      tgt_d = FLUSH;
`else
      nxt = FLUSH;
`endif
    end else if (cnt_q == '0) begin
      go = 1'b1;
`ifdef INLET_SEQ_BREAK_GAP_EN
      nxt   = is_dose ? GAP : succ;
      tgt_d = succ;
`else
      nxt = succ;
`endif
    end
    if (go) begin
      state_d = nxt;
      cnt_d   = nxt == DOSE1  ? m1(len1_d) : nxt == DOSE2 ? m1(len2_d) : nxt == DOSE3 ? m1(len3_d) :
                nxt == SETTLE ? CNT_W'(SETTLE_CYC - 1) : nxt == FLUSH ? CNT_W'(FLUSH_CYC - 1) : '0;
    end
    // Outputs are registered from the next state so they line up with the state register; zero-length doses keep their valve shut.
    drv_d  = {(state_d == DOSE1 && len1_d != '0) || state_d == FLUSH,
              state_d == DOSE2 && len2_d != '0,
              state_d == DOSE3 && len3_d != '0,
              state_d != IDLE};
    done_d = state_q == FLUSH && state_d == IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len1_q    <= '0;
      len2_q    <= '0;
      len3_q    <= '0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
      drv_q     <= '0;
`ifdef INLET_SEQ_BREAK_GAP_EN
      tgt_q     <= IDLE;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len1_q    <= len1_d;
      len2_q    <= len2_d;
      len3_q    <= len3_d;
      aborted_q <= aborted_d;
      done_q    <= done_d;
      drv_q     <= drv_d;
`ifdef INLET_SEQ_BREAK_GAP_EN
      tgt_q     <= tgt_d;
`endif
    end
  end
  assign bus.valve_soln1_o = drv_q[3];
  assign bus.valve_soln2_o = drv_q[2];
  assign bus.valve_soln3_o = drv_q[1];
  assign bus.pump_en_o     = drv_q[0];
  assign bus.busy_o        = drv_q[0];
  assign bus.done_o        = done_q;
  assign bus.aborted_o     = aborted_q;
endmodule

// File: tb/tb_inlet_dose_sequencer.sv
// tb_inlet_dose_sequencer: table, hand-written and random sequences against a per-cycle trace model.
module tb_inlet_dose_sequencer;
  localparam int W = 16;
  localparam int S = 5;
  localparam int F = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  inlet_dose_sequencer_if #(.CNT_W(W)) bus ();
  inlet_dose_sequencer #(.CNT_W(W), .SETTLE_CYC(S), .FLUSH_CYC(F)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {int l1; int l2; int l3; int ab_at; int st_at;} vec_t;
  vec_t tbl[8];
  logic [6:0] exp_q[$];
  logic [6:0] obs;
  assign obs = {bus.valve_soln1_o, bus.valve_soln2_o, bus.valve_soln3_o, bus.pump_en_o,
                bus.busy_o, bus.done_o, bus.aborted_o};
  task automatic check(input string nm, input logic [6:0] a, input logic [6:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got v1v2v3/pump/busy/done/ab=%b expected %b", nm, a, e);
    end
  endtask
  task automatic push(input logic [6:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w);
  endtask
  // Expected per-cycle outputs from cycle T+1 through the done cycle.
  task automatic build(input int l1, input int l2, input int l3, input int ab_at, output bit ab);
    int pre;
    exp_q.delete();
    push({l1 != 0, 6'b001100}, l1 == 0 ? 1 : l1);
    push({1'b0, l2 != 0, 5'b01100}, l2 == 0 ? 1 : l2);
    push({2'b00, l3 != 0, 4'b1100}, l3 == 0 ? 1 : l3);
    push(7'b0001100, S);
    pre = exp_q.size();
    ab  = ab_at > 0 && ab_at <= pre;
    if (ab) while (exp_q.size() > ab_at) void'(exp_q.pop_back());
    push(7'b1001100, F);
    push(7'b0000010, 1);
    if (ab) for (int i = ab_at; i < exp_q.size(); i++) exp_q[i][0] = 1'b1;
  endtask
  task automatic run(input string nm, input int l1, input int l2, input int l3, input int ab_at, input int st_at);
    bit ab;
    build(l1, l2, l3, ab_at, ab);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.dose1_len_i = W'(l1);
    bus.dose2_len_i = W'(l2);
    bus.dose3_len_i = W'(l3);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.dose1_len_i = W'($urandom);
    bus.dose2_len_i = W'($urandom);
    bus.dose3_len_i = W'($urandom);
    for (int c = 1; c <= exp_q.size(); c++) begin
      check($sformatf("%s c%0d", nm, c), obs, exp_q[c-1]);
      bus.abort_i = (c == ab_at);
      bus.start_i = (c == st_at);
      @(posedge clk);
      #1;
    end
    bus.abort_i = 1'b0;
    bus.start_i = 1'b0;
    check($sformatf("%s idle", nm), obs, {6'b0, ab});
  endtask
  initial begin
    tbl = '{'{3, 2, 4, 0, 0}, '{3, 0, 3, 0, 0}, '{3, 2, 4, 7, 0}, '{3, 2, 4, 15, 12},
            '{0, 0, 0, 0, 0}, '{1, 1, 1, 1, 0}, '{2, 0, 2, 5, 3}, '{2, 2, 2, 10, 0}};
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.dose1_len_i = '0;
    bus.dose2_len_i = '0;
    bus.dose3_len_i = '0;
    #1;
    check("reset_held", obs, 7'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_released", obs, 7'b0);
    foreach (tbl[i]) run($sformatf("tbl%0d", i), tbl[i].l1, tbl[i].l2, tbl[i].l3, tbl[i].ab_at, tbl[i].st_at);
    // start with abort in IDLE: abort wins, aborted stays set
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    bus.dose1_len_i = W'(3);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    check("start_abort_idle", obs, 7'b0000001);
    @(posedge clk);
    #1;
    check("start_abort_idle2", obs, 7'b0000001);
    for (int r = 0; r < 20; r++) begin
      int l1, l2, l3, n;
      l1 = $urandom_range(0, 4);
      l2 = $urandom_range(0, 4);
      l3 = $urandom_range(0, 4);
      n  = (l1 == 0 ? 1 : l1) + (l2 == 0 ? 1 : l2) + (l3 == 0 ? 1 : l3) + S + F + 1;
      run($sformatf("rnd%0d", r), l1, l2, l3, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, n),
          $urandom_range(0, n - 1));
    end
    // asynchronous reset in the middle of DOSE2
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.dose1_len_i = W'(3);
    bus.dose2_len_i = W'(2);
    bus.dose3_len_i = W'(4);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_dose2", obs, 7'b0101100);
    rst_n = 1'b0;
    #1;
    check("async_reset", obs, 7'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset c%0d", c), obs, 7'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
